// File: rtl/wt_dcache_rd_arb_if.sv
// Read-port bundle between the cache read requesters and the read arbiter.
// Carries per-port requests, tag-only flags, address fields, and the
// one-hot grant and response-valid vectors returned by the arbiter.
//   master : requester side (drives request and address, sees ack and rvld)
//   slave  : arbiter side   (sees request and address, drives ack and rvld)
interface wt_dcache_rd_arb_if #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned TagWidth = 44,
  parameter int unsigned IdxWidth = 8,
  parameter int unsigned OffWidth = 4
);
  logic [NumPorts-1:0]               rd_req_i;
  logic [NumPorts-1:0]               rd_tag_only_i;
  logic [NumPorts-1:0][TagWidth-1:0] rd_tag_i;
  logic [NumPorts-1:0][IdxWidth-1:0] rd_idx_i;
  logic [NumPorts-1:0][OffWidth-1:0] rd_off_i;
  logic [NumPorts-1:0]               rd_ack_o;
  logic [NumPorts-1:0]               rd_rvld_o;

  modport master (
    output rd_req_i, rd_tag_only_i, rd_tag_i, rd_idx_i, rd_off_i,
    input  rd_ack_o, rd_rvld_o
  );

  modport slave (
    input  rd_req_i, rd_tag_only_i, rd_tag_i, rd_idx_i, rd_off_i,
    output rd_ack_o, rd_rvld_o
  );
endinterface

// File: rtl/wt_dcache_rd_arb.sv
// Read-port arbiter for the write-through data cache arrays.
// Grants at most one read port per cycle. Ports are split into a high-priority
// class and a low-priority class, and each class has its own round-robin
// pointer. A starvation counter forces one low-priority grant after the
// low-priority ports have waited MaxStarve cycles.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   rd_bus (slave)   : per-port request, address, grant (comb), rvld (+1 cycle)
//   wr_cl_vld_i      : cacheline refill/invalidate owns the arrays, blocks all grants
//   wr_req_i         : single-word write pending, blocks low-priority grants
//   mem_req_o, mem_tag_only_o, mem_idx_o, mem_off_o : granted request to the arrays
//   mem_tag_o        : tag of the previous grant, used for the hit compare
//   busy_o           : request or response outstanding
module wt_dcache_rd_arb #(
  parameter int unsigned         NumPorts = 3,
  parameter logic [NumPorts-1:0] PrioMask = 3'b011,
  parameter int unsigned         MaxStarve = 8,
  parameter int unsigned         TagWidth = 44,
  parameter int unsigned         IdxWidth = 8,
  parameter int unsigned         OffWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wt_dcache_rd_arb_if.slave    rd_bus,
  input  logic                 wr_cl_vld_i,
  input  logic                 wr_req_i,
  output logic                 mem_req_o,
  output logic                 mem_tag_only_o,
  output logic [IdxWidth-1:0]  mem_idx_o,
  output logic [OffWidth-1:0]  mem_off_o,
  output logic [TagWidth-1:0]  mem_tag_o,
  output logic                 busy_o
);

  localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [7:0]  StarveMax = 8'(MaxStarve);

  // Returns the first requester strictly after ptr, wrapping modulo NumPorts.
  // Starting at ptr+1 and ending at ptr itself lets the last winner be granted
  // again only when it is the sole requester.
  function automatic logic [NumPorts-1:0] rr_pick(
    input logic [NumPorts-1:0] req,
    input logic [PtrW-1:0]     ptr
  );
    logic [NumPorts-1:0] gnt;
    logic                found;
    int unsigned         idx;
    gnt   = {NumPorts{1'b0}};
    found = 1'b0;
    for (int unsigned off = 1; off <= NumPorts; off++) begin
      idx = (32'(ptr) + off) % NumPorts;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

  logic [NumPorts-1:0] eligible_s;
  logic [NumPorts-1:0] hi_elig_s;
  logic [NumPorts-1:0] lo_elig_s;
  logic [NumPorts-1:0] lo_req_s;
  logic                sel_lo_s;
  logic [NumPorts-1:0] ack_s;
  logic [PtrW-1:0]     gnt_idx_s;
  logic [TagWidth-1:0] gnt_tag_s;
  logic [IdxWidth-1:0] gnt_idx_field_s;
  logic [OffWidth-1:0] gnt_off_s;
  logic                gnt_tag_only_s;

  logic [NumPorts-1:0] vld_r;
  logic [TagWidth-1:0] tag_r;
  logic [7:0]          starve_cnt_r;
  logic [PtrW-1:0]     rr_ptr_hi_r;
  logic [PtrW-1:0]     rr_ptr_lo_r;

  // Eligibility, class selection and round-robin grant within the chosen class.
  always_comb begin
    lo_req_s = rd_bus.rd_req_i & ~PrioMask;
    if (wr_cl_vld_i) begin
      eligible_s = {NumPorts{1'b0}};
    end else begin
      eligible_s = rd_bus.rd_req_i & (PrioMask | {NumPorts{~wr_req_i}});
    end
    hi_elig_s = eligible_s & PrioMask;
    lo_elig_s = eligible_s & ~PrioMask;

    // A saturated starvation counter overrides the normal high-class preference.
    if ((starve_cnt_r == StarveMax) && (|lo_elig_s)) begin
      sel_lo_s = 1'b1;
    end else if (|hi_elig_s) begin
      sel_lo_s = 1'b0;
    end else begin
      sel_lo_s = 1'b1;
    end

    if (sel_lo_s) begin
      ack_s = rr_pick(lo_elig_s, rr_ptr_lo_r);
    end else begin
      ack_s = rr_pick(hi_elig_s, rr_ptr_hi_r);
    end
  end

  // One-hot AND-OR mux of the granted port's fields; all zero without a grant.
  always_comb begin
    gnt_idx_s       = {PtrW{1'b0}};
    gnt_tag_s       = {TagWidth{1'b0}};
    gnt_idx_field_s = {IdxWidth{1'b0}};
    gnt_off_s       = {OffWidth{1'b0}};
    gnt_tag_only_s  = 1'b0;
    for (int k = 0; k < NumPorts; k++) begin
      gnt_idx_s       = gnt_idx_s | (PtrW'(k) & {PtrW{ack_s[k]}});
      gnt_tag_s       = gnt_tag_s | (rd_bus.rd_tag_i[k] & {TagWidth{ack_s[k]}});
      gnt_idx_field_s = gnt_idx_field_s | (rd_bus.rd_idx_i[k] & {IdxWidth{ack_s[k]}});
      gnt_off_s       = gnt_off_s | (rd_bus.rd_off_i[k] & {OffWidth{ack_s[k]}});
      gnt_tag_only_s  = gnt_tag_only_s | (rd_bus.rd_tag_only_i[k] & ack_s[k]);
    end
  end

  // Response pipeline, round-robin pointers and starvation counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_r        <= {NumPorts{1'b0}};
      tag_r        <= {TagWidth{1'b0}};
      starve_cnt_r <= 8'd0;
      rr_ptr_hi_r  <= PtrW'(NumPorts - 1);
      rr_ptr_lo_r  <= PtrW'(NumPorts - 1);
    end else begin
      vld_r <= ack_s;
      if (|ack_s) begin
        tag_r <= gnt_tag_s;
        if (sel_lo_s) begin
          rr_ptr_lo_r <= gnt_idx_s;
        end else begin
          rr_ptr_hi_r <= gnt_idx_s;
        end
      end else begin
        tag_r <= tag_r;
      end
      // Counts raw low-priority waiting, including cycles lost to writes/refills.
      if (|(ack_s & ~PrioMask)) begin
        starve_cnt_r <= 8'd0;
      end else if ((|lo_req_s) && (starve_cnt_r != StarveMax)) begin
        starve_cnt_r <= starve_cnt_r + 8'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  assign rd_bus.rd_ack_o  = ack_s;
  assign rd_bus.rd_rvld_o = vld_r;
  assign mem_req_o        = |ack_s;
  assign mem_tag_only_o   = gnt_tag_only_s;
  assign mem_idx_o        = gnt_idx_field_s;
  assign mem_off_o        = gnt_off_s;
  assign mem_tag_o        = tag_r;
  assign busy_o           = (|rd_bus.rd_req_i) | (|vld_r);

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Directed testbench for wt_dcache_rd_arb (3 ports, ports 0/1 high priority,
// starvation threshold 4). Inputs change 1ns after the rising edge; outputs
// are compared on the falling edge.
module tb_wt_dcache_rd_arb;
  logic        clk;
  logic        rst_i;
  logic        wr_cl_vld_i;
  logic        wr_req_i;
  logic        mem_req_o;
  logic        mem_tag_only_o;
  logic [7:0]  mem_idx_o;
  logic [3:0]  mem_off_o;
  logic [43:0] mem_tag_o;
  logic        busy_o;

  int vectors;
  int miscompares;

  wt_dcache_rd_arb_if #(.NumPorts(3), .TagWidth(44), .IdxWidth(8), .OffWidth(4)) bus ();

  wt_dcache_rd_arb #(
    .NumPorts(3), .PrioMask(3'b011), .MaxStarve(4),
    .TagWidth(44), .IdxWidth(8), .OffWidth(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .rd_bus(bus),
    .wr_cl_vld_i(wr_cl_vld_i), .wr_req_i(wr_req_i),
    .mem_req_o(mem_req_o), .mem_tag_only_o(mem_tag_only_o),
    .mem_idx_o(mem_idx_o), .mem_off_o(mem_off_o),
    .mem_tag_o(mem_tag_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    wr_cl_vld_i = 1'b0;
    wr_req_i = 1'b0;
    bus.rd_req_i = 3'b000;
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b1;
    bus.rd_req_i = 3'b011;
    @(negedge clk);
    vectors++;
    if (bus.rd_ack_o !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_ack got=%b exp=%b", bus.rd_ack_o, 3'b001);
    end
    vectors++;
    if (bus.rd_rvld_o !== 3'b000 || mem_tag_o !== 44'h0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state got rvld=%b tag=%h busy=%b exp rvld=000 tag=0 busy=1",
               bus.rd_rvld_o, mem_tag_o, busy_o);
    end
    next_cycle();
    rst_i = 1'b0;
    bus.rd_req_i = 3'b000;
    @(negedge clk);
    vectors++;
    if (bus.rd_rvld_o !== 3'b000 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset got rvld=%b busy=%b mreq=%b exp 000/0/0",
               bus.rd_rvld_o, busy_o, mem_req_o);
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    logic [2:0]  exp_ack;
    logic [2:0]  prev_ack;
    logic [43:0] prev_tag;
    logic [7:0]  exp_idx;
    do_reset();
    bus.rd_req_i = 3'b011;
    prev_ack = 3'b000;
    prev_tag = 44'h0;
    for (int i = 0; i < 6; i++) begin
      exp_ack = (i % 2 == 0) ? 3'b001 : 3'b010;
      exp_idx = (i % 2 == 0) ? 8'h10 : 8'h21;
      @(negedge clk);
      vectors++;
      if (bus.rd_ack_o !== exp_ack || mem_req_o !== 1'b1 || mem_idx_o !== exp_idx) begin
        miscompares++;
        $display("FAIL alt_ack[%0d] got ack=%b mreq=%b idx=%h exp ack=%b mreq=1 idx=%h",
                 i, bus.rd_ack_o, mem_req_o, mem_idx_o, exp_ack, exp_idx);
      end
      vectors++;
      if (bus.rd_rvld_o !== prev_ack || mem_tag_o !== prev_tag) begin
        miscompares++;
        $display("FAIL alt_rvld[%0d] got rvld=%b tag=%h exp rvld=%b tag=%h",
                 i, bus.rd_rvld_o, mem_tag_o, prev_ack, prev_tag);
      end
      prev_ack = exp_ack;
      prev_tag = (i % 2 == 0) ? 44'h111 : 44'h222;
      next_cycle();
    end
    // Port 1 carries the tag-only flag and offset 2.
    bus.rd_req_i = 3'b010;
    @(negedge clk);
    vectors++;
    if (mem_tag_only_o !== 1'b1 || mem_off_o !== 4'h2 || bus.rd_ack_o !== 3'b010) begin
      miscompares++;
      $display("FAIL alt_fields got to=%b off=%h ack=%b exp to=1 off=2 ack=010",
               mem_tag_only_o, mem_off_o, bus.rd_ack_o);
    end
    next_cycle();
    bus.rd_req_i = 3'b000;
  endtask

  task automatic test_starve();
    logic [2:0] exp_ack;
    logic [7:0] exp_cnt;
    do_reset();
    bus.rd_req_i = 3'b111;
    for (int i = 0; i < 10; i++) begin
      exp_cnt = 8'(i % 5);
      exp_ack = (i % 5 == 4) ? 3'b100 : (((i % 5) % 2 == 0) ? 3'b001 : 3'b010);
      @(negedge clk);
      vectors++;
      if (bus.rd_ack_o !== exp_ack || dut.starve_cnt_r !== exp_cnt) begin
        miscompares++;
        $display("FAIL starve[%0d] got ack=%b cnt=%0d exp ack=%b cnt=%0d",
                 i, bus.rd_ack_o, dut.starve_cnt_r, exp_ack, exp_cnt);
      end
      next_cycle();
    end
    bus.rd_req_i = 3'b000;
  endtask

  task automatic test_wr_cl();
    do_reset();
    bus.rd_req_i = 3'b111;
    wr_cl_vld_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.rd_ack_o !== 3'b000 || mem_req_o !== 1'b0 || mem_idx_o !== 8'h00) begin
      miscompares++;
      $display("FAIL wr_cl_block got ack=%b mreq=%b idx=%h exp 000/0/00",
               bus.rd_ack_o, mem_req_o, mem_idx_o);
    end
    next_cycle();
    wr_cl_vld_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.rd_ack_o !== 3'b001 || mem_req_o !== 1'b1 || bus.rd_rvld_o !== 3'b000) begin
      miscompares++;
      $display("FAIL wr_cl_release got ack=%b mreq=%b rvld=%b exp 001/1/000",
               bus.rd_ack_o, mem_req_o, bus.rd_rvld_o);
    end
    next_cycle();
    bus.rd_req_i = 3'b000;
  endtask

  task automatic test_wr_req();
    do_reset();
    bus.rd_req_i = 3'b100;
    wr_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.rd_ack_o !== 3'b000) begin
        miscompares++;
        $display("FAIL wr_req_block[%0d] got ack=%b exp 000", i, bus.rd_ack_o);
      end
      next_cycle();
    end
    // High-priority port still wins while the write is pending.
    bus.rd_req_i = 3'b101;
    @(negedge clk);
    vectors++;
    if (bus.rd_ack_o !== 3'b001 || dut.starve_cnt_r !== 8'd3) begin
      miscompares++;
      $display("FAIL wr_req_hi got ack=%b cnt=%0d exp ack=001 cnt=3",
               bus.rd_ack_o, dut.starve_cnt_r);
    end
    next_cycle();
    bus.rd_req_i = 3'b100;
    wr_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.rd_ack_o !== 3'b100 || dut.starve_cnt_r !== 8'd4) begin
      miscompares++;
      $display("FAIL wr_req_release got ack=%b cnt=%0d exp ack=100 cnt=4",
               bus.rd_ack_o, dut.starve_cnt_r);
    end
    next_cycle();
    bus.rd_req_i = 3'b000;
    @(negedge clk);
    vectors++;
    if (dut.starve_cnt_r !== 8'd0 || bus.rd_rvld_o !== 3'b100 || mem_tag_o !== 44'h333) begin
      miscompares++;
      $display("FAIL wr_req_clear got cnt=%0d rvld=%b tag=%h exp cnt=0 rvld=100 tag=333",
               dut.starve_cnt_r, bus.rd_rvld_o, mem_tag_o);
    end
    next_cycle();
  endtask

  task automatic test_tag_rst();
    do_reset();
    bus.rd_tag_i[1] = 44'hABC;
    bus.rd_req_i = 3'b010;
    @(negedge clk);
    vectors++;
    if (bus.rd_ack_o !== 3'b010) begin
      miscompares++;
      $display("FAIL tag_grant got ack=%b exp 010", bus.rd_ack_o);
    end
    next_cycle();
    bus.rd_req_i = 3'b000;
    rst_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_tag_o !== 44'hABC || bus.rd_rvld_o !== 3'b010) begin
      miscompares++;
      $display("FAIL tag_resp got tag=%h rvld=%b exp tag=abc rvld=010",
               mem_tag_o, bus.rd_rvld_o);
    end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.rd_rvld_o !== 3'b000 || mem_tag_o !== 44'h0) begin
      miscompares++;
      $display("FAIL tag_rst_drop got rvld=%b tag=%h exp rvld=000 tag=0",
               bus.rd_rvld_o, mem_tag_o);
    end
    next_cycle();
    bus.rd_tag_i[1] = 44'h222;
  endtask

  task automatic test_drop_hold();
    do_reset();
    bus.rd_req_i = 3'b001;
    next_cycle();
    bus.rd_req_i = 3'b000;
    @(negedge clk);
    vectors++;
    if (bus.rd_ack_o !== 3'b000 || bus.rd_rvld_o !== 3'b001 || mem_tag_o !== 44'h111
        || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_first got ack=%b rvld=%b tag=%h busy=%b exp 000/001/111/1",
               bus.rd_ack_o, bus.rd_rvld_o, mem_tag_o, busy_o);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (bus.rd_rvld_o !== 3'b000 || mem_tag_o !== 44'h111 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_hold got rvld=%b tag=%h busy=%b exp 000/111/0",
               bus.rd_rvld_o, mem_tag_o, busy_o);
    end
    next_cycle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_i = 1'b1;
    wr_cl_vld_i = 1'b0;
    wr_req_i = 1'b0;
    bus.rd_req_i = 3'b000;
    bus.rd_tag_only_i = 3'b010;
    bus.rd_tag_i[0] = 44'h111;
    bus.rd_tag_i[1] = 44'h222;
    bus.rd_tag_i[2] = 44'h333;
    bus.rd_idx_i[0] = 8'h10;
    bus.rd_idx_i[1] = 8'h21;
    bus.rd_idx_i[2] = 8'h32;
    bus.rd_off_i[0] = 4'h1;
    bus.rd_off_i[1] = 4'h2;
    bus.rd_off_i[2] = 4'h3;
    #1;
    test_reset();
    test_alternate();
    test_starve();
    test_wr_cl();
    test_wr_req();
    test_tag_rst();
    test_drop_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wt_dcache_rd_arb.md
WT_DCACHE_RD_ARB -- requirements
Module: wt_dcache_rd_arb

Interface
REQ-001: Parameter NumPorts, default 3, number of requesting read ports; SHALL be 1..8.
REQ-002: Parameter PrioMask [NumPorts-1:0], default 3'b011, bit k=1 marks port k high-priority, 0 low-priority.
REQ-003: Parameter MaxStarve, default 8, the low-priority starvation threshold in cycles; SHALL be 1..255.
REQ-004: Parameter TagWidth/IdxWidth/OffWidth, defaults 44/8/4, the tag, index and offset widths.
REQ-005: clk_i  in  1  clock; the block SHALL use this single clock and all state SHALL update on its rising edge.
REQ-006: rst_i  in  1  reset, synchronous and active-high.
REQ-007: rd_req_i  in  NumPorts  per-port read request.
REQ-008: rd_tag_only_i  in  NumPorts  per-port tag-only lookup flag.
REQ-009: rd_tag_i/rd_idx_i/rd_off_i  in  NumPorts x Tag/Idx/OffWidth  per-port address fields.
REQ-010: wr_cl_vld_i  in  1  cacheline refill/invalidate owns the array; blocks all grants.
REQ-011: wr_req_i  in  1  single-word write pending; blocks low-priority grants only.
REQ-012: rd_ack_o  out  NumPorts  one-hot grant, combinational.
REQ-013: rd_rvld_o  out  NumPorts  one-hot response valid, one cycle after rd_ack_o.
REQ-014: mem_req_o, mem_tag_only_o, mem_idx_o, mem_off_o  out  1/1/IdxWidth/OffWidth  muxed request to the cache arrays.
REQ-015: mem_tag_o  out  TagWidth  registered tag of the previous grant, used for the hit compare.
REQ-016: busy_o  out  1  any request or response outstanding.

Function
REQ-017: Grant SHALL be issued only when wr_cl_vld_i=0 and at least one eligible port requests; at most one rd_ack_o bit SHALL be set per cycle.
REQ-018: Eligible set SHALL be: high-priority requesters, plus low-priority requesters when wr_req_i=0.
REQ-019: Class selection SHALL be: low class if starve_cnt==MaxStarve and an eligible low-priority requester exists; else high class if any high-priority requester; else low class.
REQ-020: Within a class, the grant SHALL go to the first requester at index > rr_ptr[class] (cyclic, modulo NumPorts); rr_ptr[class] SHALL load the granted index on grant.
REQ-021: starve_cnt SHALL increment, saturating at MaxStarve, in each cycle in which any low-priority port requests and none is acked; it SHALL clear on a low-priority ack and hold otherwise.
REQ-022: mem_req_o SHALL equal |rd_ack_o; mem_idx_o, mem_off_o and mem_tag_only_o SHALL be the granted port's fields (0 when there is no grant).
REQ-023: On a grant the block SHALL register vld_q<=rd_ack_o and tag_q<=granted tag; rd_rvld_o=vld_q; mem_tag_o=tag_q; latency SHALL be exactly 1 cycle.
REQ-024: tag_q SHALL hold its value in cycles without a grant; vld_q SHALL clear.
REQ-025: busy_o SHALL be |rd_req_i | |vld_q.
REQ-026: If PrioMask is all ones, starve_cnt SHALL remain 0; if it is all zeros, wr_req_i SHALL block every grant.
REQ-027: With NumPorts=1, the sole port SHALL be granted whenever it is eligible, and round-robin SHALL be degenerate.
REQ-028: A request dropped before its ack SHALL have no effect; the arbiter SHALL NOT hold a grant across cycles.

Reset
REQ-029: With rst_i=1 at a clock edge, the block SHALL load vld_q=0, tag_q=0, starve_cnt=0 and rr_ptr[both]=NumPorts-1, so that port 0 wins first.
REQ-030: During reset cycles, rd_ack_o SHALL stay combinational per REQ-017..020 from the reset state; rd_rvld_o SHALL be 0 in the cycle after reset.
REQ-031: A response pending when reset asserts SHALL be dropped, with no rd_rvld_o pulse.

Verification
REQ-032: NumPorts=3, PrioMask=011: ports 0 and 1 request continuously -> acks alternate 0,1,0,1; rd_rvld_o follows one cycle later.
REQ-033: Ports 0, 1 and 2 request continuously, MaxStarve=4 -> port 2 is acked on the 5th cycle, then the sequence repeats with starve_cnt 0..4.
REQ-034: wr_cl_vld_i=1 with all ports requesting -> rd_ack_o=000 and mem_req_o=0; on the next cycle with wr_cl_vld_i=0, port 0 is acked.
REQ-035: Only port 2 requesting with wr_req_i=1 for 3 cycles -> no ack and starve_cnt=3; wr_req_i drops -> port 2 is acked and starve_cnt becomes 0.
REQ-036: Grant to port 1 with tag 0xABC -> the next cycle has mem_tag_o=0xABC and rd_rvld_o=010; rst_i in that cycle -> rd_rvld_o=000 the cycle after.
